// File: rtl/sample_framer.sv
// Per-channel averaging framer between the ADC capture block and the sample FIFO.
// Emits one word per cycle (header > held word > new average) and pulses frame_end on each frame's last data word.
module sample_framer #(
    parameter int NUM_CHANNELS    = 8,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int MAX_AVG_LOG2    = 4,
    parameter int FRAME_W         = 8,
    parameter int SAMPLE_WIDTH    = NUM_CHANNELS * BITS_PER_SAMPLE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [SAMPLE_WIDTH-1:0]               in,
    input  logic                                  in_valid,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]     avg_log2,
    input  logic [FRAME_W-1:0]                    frame_len,
    input  logic                                  header_en,
    output logic [SAMPLE_WIDTH-1:0]               out,
    output logic                                  out_valid,
    output logic                                  frame_end,
    output logic [7:0]                            drop_ctr
);

    localparam int          AW        = $clog2(MAX_AVG_LOG2 + 1);
    localparam int          ACC_W     = BITS_PER_SAMPLE + MAX_AVG_LOG2;
    localparam int          GW        = MAX_AVG_LOG2 + 1;
    localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

    if (BITS_PER_SAMPLE < 8) begin : g_bad_bps
        $error("sample_framer: BITS_PER_SAMPLE must be >= 8");
    end
    if (SAMPLE_WIDTH < 48) begin : g_bad_width
        $error("sample_framer: SAMPLE_WIDTH must be >= 48 to hold a header word");
    end
    if (SAMPLE_WIDTH != NUM_CHANNELS * BITS_PER_SAMPLE) begin : g_bad_pack
        $error("sample_framer: SAMPLE_WIDTH must equal NUM_CHANNELS*BITS_PER_SAMPLE");
    end
    if (MAX_AVG_LOG2 < 1) begin : g_bad_avg
        $error("sample_framer: MAX_AVG_LOG2 must be >= 1");
    end

    // Configuration shadows: only these are used by the datapath.
    logic [AW-1:0]           a_sh_q;
    logic [FRAME_W-1:0]      flen_sh_q;
    logic                    hen_sh_q;
    logic [AW-1:0]           a_clamped;

    logic [GW-1:0]           grp_cnt_q, grp_cnt_d;
    logic [GW-1:0]           grp_last;
    logic                    group_done;
    logic [SAMPLE_WIDTH-1:0] cand_word;

    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0]      frame_lim;
    logic                    frame_last;

    logic [15:0]             seq_q, seq_d;
    logic                    hdr_pending_q, hdr_pending_d;
    logic                    hdr_slot;
    logic [SAMPLE_WIDTH-1:0] hdr_word;

    logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;

    logic [SAMPLE_WIDTH-1:0] out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_end_q, frame_end_d;
    logic [7:0]              drop_q, drop_d;
    logic                    drop_inc;

    logic                    data_emit;
    logic [SAMPLE_WIDTH-1:0] data_word;

    assign a_clamped = (avg_log2 > AW'(MAX_AVG_LOG2)) ? AW'(MAX_AVG_LOG2) : avg_log2;

    // A group completes on its 2^A-th sample; >= covers a group counter left above a smaller new A.
    assign grp_last   = (GW'(1) << a_sh_q) - GW'(1);
    assign group_done = in_valid && (grp_cnt_q >= grp_last);

    always_comb begin
        grp_cnt_d = grp_cnt_q;
        if (in_valid) begin
            grp_cnt_d = group_done ? '0 : grp_cnt_q + GW'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] acc_sum;

        assign acc_sum = acc_q + ACC_W'(in[gi*BITS_PER_SAMPLE +: BITS_PER_SAMPLE]);
        assign cand_word[gi*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] = BITS_PER_SAMPLE'(acc_sum >> a_sh_q);

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
            end else if (in_valid) begin
                acc_q <= group_done ? '0 : acc_sum;
            end
        end
    end

    assign frame_lim  = (flen_sh_q == '0) ? FRAME_W'(1) : flen_sh_q;
    assign frame_last = (frame_cnt_q + FRAME_W'(1)) == frame_lim;

    assign hdr_slot = hdr_pending_q && hen_sh_q;

    // Drops only happen in a header cycle: elsewhere the held word leaves as the new one enters.
    assign drop_inc = hdr_slot && group_done && hold_full_q;
    assign drop_d   = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    // Header carries the drop count that is visible on drop_ctr alongside it.
    assign hdr_word = SAMPLE_WIDTH'({8'(a_sh_q), drop_d, seq_q, HDR_MAGIC});

    always_comb begin
        out_d         = out_q;
        out_valid_d   = 1'b0;
        frame_end_d   = 1'b0;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        hdr_pending_d = hdr_pending_q;
        seq_d         = seq_q;
        frame_cnt_d   = frame_cnt_q;
        data_emit     = 1'b0;
        data_word     = hold_q;

        if (hdr_slot) begin
            out_d         = hdr_word;
            out_valid_d   = 1'b1;
            seq_d         = seq_q + 16'd1;
            hdr_pending_d = 1'b0;
            if (group_done && !hold_full_q) begin
                hold_d      = cand_word;
                hold_full_d = 1'b1;
            end
        end else begin
            hdr_pending_d = 1'b0;
            if (hold_full_q) begin
                data_emit = 1'b1;
                data_word = hold_q;
                if (group_done) begin
                    hold_d = cand_word;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (group_done) begin
                data_emit = 1'b1;
                data_word = cand_word;
            end

            if (data_emit) begin
                out_d       = data_word;
                out_valid_d = 1'b1;
                if (frame_last) begin
                    frame_end_d   = 1'b1;
                    frame_cnt_d   = '0;
                    hdr_pending_d = 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q        <= a_clamped;
            flen_sh_q     <= frame_len;
            hen_sh_q      <= header_en;
            grp_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            seq_q         <= '0;
            hdr_pending_q <= 1'b1;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            frame_end_q   <= 1'b0;
            drop_q        <= '0;
        end else begin
            // New configuration is latched at the frame boundary, ready for the following header.
            if (frame_end_d) begin
                a_sh_q    <= a_clamped;
                flen_sh_q <= frame_len;
                hen_sh_q  <= header_en;
            end
            grp_cnt_q     <= grp_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            seq_q         <= seq_d;
            hdr_pending_q <= hdr_pending_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_end_q   <= frame_end_d;
            drop_q        <= drop_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign frame_end = frame_end_q;
    assign drop_ctr  = drop_q;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: per-cycle scoreboard from a reference model, table-driven scenarios,
// and hand-written sequences for averaging, frame-length changes and mid-operation reset.
module tb_sample_framer;

    localparam int NC   = 8;
    localparam int BPS  = 16;
    localparam int MAXA = 4;
    localparam int FW   = 8;
    localparam int SW   = NC * BPS;
    localparam int AW   = $clog2(MAXA + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] in = '0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] avg_log2 = '0;
    logic [FW-1:0] frame_len = 8'd4;
    logic          header_en = 1'b0;
    logic [SW-1:0] out;
    logic          out_valid;
    logic          frame_end;
    logic [7:0]    drop_ctr;

    sample_framer #(
        .NUM_CHANNELS(NC), .BITS_PER_SAMPLE(BPS), .MAX_AVG_LOG2(MAXA), .FRAME_W(FW), .SAMPLE_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .avg_log2(avg_log2),
        .frame_len(frame_len), .header_en(header_en), .out(out), .out_valid(out_valid),
        .frame_end(frame_end), .drop_ctr(drop_ctr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [SW-1:0] w;
        logic          fe;
        logic [7:0]    drop;
    } exp_t;

    typedef struct packed {
        logic [SW-1:0] w;
        logic          fe;
        logic [7:0]    drop;
        logic [31:0]   cyc;
    } cap_t;

    typedef struct {
        logic          hen;
        logic [AW-1:0] a;
        logic [FW-1:0] flen;
        int            gap;
        int            n;
        int            words;
        int            drops;
        int            hdrs;
        int            fes;
    } vec_t;

    exp_t sb_q[$];
    cap_t cap_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    // Reference model state
    logic [AW-1:0] m_a;
    logic [FW-1:0] m_flen;
    logic          m_hen;
    int            m_grp;
    int            m_sum[NC];
    logic          m_hold_v;
    logic [SW-1:0] m_hold;
    logic          m_pend;
    logic [15:0]   m_seq;
    int            m_fcnt;
    logic [7:0]    m_drop;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [AW-1:0] clampa(input logic [AW-1:0] a);
        return (a > AW'(MAXA)) ? AW'(MAXA) : a;
    endfunction

    function automatic logic [SW-1:0] mk_word(input int i);
        logic [SW-1:0] w;
        for (int k = 0; k < NC; k++) w[k*BPS +: BPS] = 16'($urandom_range(0, 65535));
        w[BPS-1:0] = 16'(i + 1);
        return w;
    endfunction

    task automatic model_step();
        exp_t          e;
        logic          cv;
        logic          have;
        logic [SW-1:0] cw;
        logic [SW-1:0] dw;
        e = '0; cv = 1'b0; have = 1'b0; cw = '0; dw = '0;
        if (rst) begin
            m_a = clampa(avg_log2); m_flen = frame_len; m_hen = header_en;
            m_grp = 0;
            for (int k = 0; k < NC; k++) m_sum[k] = 0;
            m_hold_v = 1'b0; m_hold = '0; m_pend = 1'b1; m_seq = '0; m_fcnt = 0; m_drop = '0;
        end else begin
            if (in_valid) begin
                m_grp++;
                for (int k = 0; k < NC; k++) m_sum[k] += int'(in[k*BPS +: BPS]);
                if (m_grp >= (1 << m_a)) begin
                    cv = 1'b1;
                    for (int k = 0; k < NC; k++) begin
                        cw[k*BPS +: BPS] = 16'(m_sum[k] >> m_a);
                        m_sum[k] = 0;
                    end
                    m_grp = 0;
                end
            end
            if (m_pend && m_hen) begin
                if (cv) begin
                    if (m_hold_v) begin
                        if (m_drop != 8'hFF) m_drop++;
                    end else begin
                        m_hold = cw; m_hold_v = 1'b1;
                    end
                end
                e.v = 1'b1;
                e.w[15:0]  = 16'hA5A5;
                e.w[31:16] = m_seq;
                e.w[39:32] = m_drop;
                e.w[47:40] = 8'(m_a);
                m_seq++;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b0;
                if (m_hold_v) begin
                    dw = m_hold; have = 1'b1;
                    if (cv) m_hold = cw;
                    else m_hold_v = 1'b0;
                end else if (cv) begin
                    dw = cw; have = 1'b1;
                end
                if (have) begin
                    e.v = 1'b1; e.w = dw; m_fcnt++;
                    if (m_fcnt >= ((m_flen == 0) ? 1 : int'(m_flen))) begin
                        e.fe = 1'b1; m_fcnt = 0; m_pend = 1'b1;
                        m_a = clampa(avg_log2); m_flen = frame_len; m_hen = header_en;
                    end
                end
            end
        end
        e.drop = m_drop;
        sb_q.push_back(e);
    endtask

    // One clock: drive, predict, clock, compare against the scoreboard, log valid words.
    task automatic step(input logic v, input logic [SW-1:0] d);
        exp_t          e;
        cap_t          c;
        logic [159:0]  a_pk;
        logic [159:0]  e_pk;
        in_valid = v;
        in = d;
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            a_pk = 160'({out_valid, (out_valid ? out : {SW{1'b0}}), frame_end, drop_ctr});
            e_pk = 160'({e.v, e.w, e.fe, e.drop});
            chk($sformatf("cycle%0d", cyc), a_pk, e_pk);
        end
        if (out_valid) begin
            c.w = out; c.fe = frame_end; c.drop = drop_ctr; c.cyc = 32'(cyc);
            cap_q.push_back(c);
        end
        cyc++;
    endtask

    task automatic do_reset(input logic hen, input logic [AW-1:0] a, input logic [FW-1:0] flen);
        header_en = hen; avg_log2 = a; frame_len = flen;
        rst = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        rst = 1'b0;
        cap_q.delete();
        cyc = 0;
    endtask

    initial begin
        logic [SW-1:0] w;
        logic [SW-1:0] w_exp;
        logic [9:0]    fe_exp;
        int            words, hdrs, fes, last;
        logic          mono;

        //          hen   a     flen  gap n   words drops hdrs fes
        vecs[0] = '{1'b0, 3'd0, 8'd4, 10, 12, 12,   0,    0,   3};
        vecs[1] = '{1'b1, 3'd0, 8'd2, 3,  8,  8,    0,    5,   4};
        vecs[2] = '{1'b1, 3'd0, 8'd3, 1,  20, 16,   4,    6,   5};
        vecs[3] = '{1'b1, 3'd2, 8'd3, 1,  24, 6,    0,    3,   2};
        vecs[4] = '{1'b0, 3'd7, 8'd0, 2,  32, 2,    0,    0,   2};
        vecs[5] = '{1'b1, 3'd1, 8'd5, 1,  30, 15,   0,    4,   3};

        for (int vi = 0; vi < 6; vi++) begin
            do_reset(vecs[vi].hen, vecs[vi].a, vecs[vi].flen);
            for (int i = 0; i < vecs[vi].n; i++)
                for (int g = 0; g < vecs[vi].gap; g++)
                    step(g == 0, mk_word(i));
            repeat (10) step(1'b0, '0);
            words = 0; hdrs = 0; fes = 0; last = -1; mono = 1'b1;
            foreach (cap_q[j]) begin
                if (cap_q[j].w[15:0] == 16'hA5A5) begin
                    chk($sformatf("v%0d_hdr_seq", vi), 160'(cap_q[j].w[31:16]), 160'(hdrs));
                    chk($sformatf("v%0d_hdr_avg", vi), 160'(cap_q[j].w[47:40]), 160'(clampa(vecs[vi].a)));
                    hdrs++;
                end else begin
                    words++;
                    if (cap_q[j].fe) fes++;
                    if (int'(cap_q[j].w[15:0]) <= last) mono = 1'b0;
                    last = int'(cap_q[j].w[15:0]);
                end
            end
            chk($sformatf("v%0d_words", vi), 160'(words), 160'(vecs[vi].words));
            chk($sformatf("v%0d_drops", vi), 160'(drop_ctr), 160'(vecs[vi].drops));
            chk($sformatf("v%0d_hdrs", vi), 160'(hdrs), 160'(vecs[vi].hdrs));
            chk($sformatf("v%0d_frame_ends", vi), 160'(fes), 160'(vecs[vi].fes));
            chk($sformatf("v%0d_in_order", vi), 160'(mono), 160'(1));
            $display("vector %0d: words=%0d hdrs=%0d frame_ends=%0d drop_ctr=%0d", vi, words, hdrs, fes, drop_ctr);
        end

        // Averaging over four samples: ch0 (10+11+12+14)/4 truncates to 11.
        do_reset(1'b0, 3'd2, 8'd8);
        w = {SW{1'b1}};
        w[15:0] = 16'd10; step(1'b1, w);
        w[15:0] = 16'd11; step(1'b1, w);
        w[15:0] = 16'd12; step(1'b1, w);
        w[15:0] = 16'd14; step(1'b1, w);
        repeat (4) step(1'b0, '0);
        w_exp = {SW{1'b1}};
        w_exp[15:0] = 16'd11;
        chk("avg_count", 160'(cap_q.size()), 160'(1));
        if (cap_q.size() > 0) begin
            chk("avg_word", 160'(cap_q[0].w), 160'(w_exp));
            chk("avg_latency", 160'(cap_q[0].cyc), 160'(3));
        end
        $display("averaging: %0d word(s) captured", cap_q.size());

        // frame_len 4 -> 2 mid-frame, then 0: frame_end on words 4, 6, 7, 8, 9, 10.
        do_reset(1'b0, 3'd0, 8'd4);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) frame_len = 8'd2;
            if (i == 5) frame_len = 8'd0;
            for (int g = 0; g < 3; g++) step(g == 0, mk_word(i));
        end
        repeat (3) step(1'b0, '0);
        fe_exp = 10'b1111101000;
        chk("flen_count", 160'(cap_q.size()), 160'(10));
        for (int j = 0; j < 10 && j < cap_q.size(); j++) begin
            chk($sformatf("flen_fe%0d", j + 1), 160'(cap_q[j].fe), 160'(fe_exp[j]));
            chk($sformatf("flen_lat%0d", j + 1), 160'(cap_q[j].cyc), 160'(3 * j));
        end
        $display("frame_len change: %0d words captured", cap_q.size());

        // Reset for one cycle mid-group and mid-frame.
        do_reset(1'b1, 3'd2, 8'd3);
        w = '0;
        for (int k = 0; k < NC; k++) w[k*BPS +: BPS] = 16'd3000;
        w[15:0] = 16'd1000;
        repeat (6) step(1'b1, w);
        rst = 1'b1;
        step(1'b1, w);
        rst = 1'b0;
        chk("rst_out", 160'(out), 160'(0));
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_frame_end", 160'(frame_end), 160'(0));
        chk("rst_drop_ctr", 160'(drop_ctr), 160'(0));
        cap_q.delete();
        cyc = 0;
        for (int k = 0; k < NC; k++) w[k*BPS +: BPS] = 16'd200;
        w[15:0] = 16'd100;
        repeat (4) step(1'b1, w);
        repeat (4) step(1'b0, '0);
        chk("rst_count", 160'(cap_q.size()), 160'(2));
        if (cap_q.size() >= 2) begin
            chk("rst_hdr_magic", 160'(cap_q[0].w[15:0]), 160'(16'hA5A5));
            chk("rst_hdr_seq", 160'(cap_q[0].w[31:16]), 160'(0));
            chk("rst_first_data", 160'(cap_q[1].w), 160'(w));
        end
        $display("reset sequence: %0d words captured after release", cap_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Sits between the ADC capture block and the sample FIFO.
- Averages each channel over 2^avg_log2 input samples and counts output samples into frames of frame_len words.
- Optionally prefixes each frame with a header word carrying a sequence number and a drop count.
- Drives a one-cycle frame_end pulse used as the SPI resync / chip-select. This replaces the fixed 48-sample flush counter with a runtime-configurable framer.

Parameters:
NUM_CHANNELS, 8, channels packed in each sample word
BITS_PER_SAMPLE, 16, unsigned bits per channel; must be >= 8
MAX_AVG_LOG2, 4, largest averaging exponent; sets the accumulator headroom
FRAME_W, 8, width of frame_len
SAMPLE_WIDTH, NUM_CHANNELS*BITS_PER_SAMPLE, word width; elaboration error if < 48

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in  in  SAMPLE_WIDTH  ADC word; channel k occupies bits [k*BITS_PER_SAMPLE +: BITS_PER_SAMPLE]
in_valid  in  1  in is valid this cycle
avg_log2  in  $clog2(MAX_AVG_LOG2+1)  averaging exponent; values above MAX_AVG_LOG2 are clamped
frame_len  in  FRAME_W  data words per frame; 0 is treated as 1
header_en  in  1  insert a header word at the start of each frame
out  out  SAMPLE_WIDTH  output word to the FIFO
out_valid  out  1  out is valid this cycle; there is no backpressure
frame_end  out  1  one-cycle pulse on the last data word of each frame
drop_ctr  out  8  count of dropped words; saturates at 255

Behaviour:
- Reset values: out=0, out_valid=0, frame_end=0, drop_ctr=0. Accumulators, group counter and frame counter are 0; seq=0; hold register is empty; hdr_pending=1.
- Config shadowing:
  - avg_log2, frame_len and header_en are copied into shadow registers every cycle while rst=1, and again in the cycle frame_end is driven.
  - All logic uses only the shadows, so mid-frame input changes take effect at the next frame.
- Averaging:
  - Per-channel accumulator width is BITS_PER_SAMPLE+MAX_AVG_LOG2, so it never overflows.
  - Each in_valid adds to the accumulators and increments the group counter.
  - On the 2^A-th sample (A = shadow avg_log2): form avg_k = (acc_k + in_k) >> A, truncated. Then clear the accumulators and the group counter.
  - With A=0 the input passes through unchanged. The completed word is the "data candidate" for that cycle.
- Output slot: exactly one word is registered per cycle. Priority: header > hold register > new candidate.
  - Header: when hdr_pending=1 and shadow header_en=1, the slot carries {magic 16'hA5A5, seq[15:0], drop_ctr[7:0], A zero-extended to 8 bits, zeros in the upper bits}, packed LSB-first in that order.
  - After the header is emitted: seq increments (wrapping at 16 bits) and hdr_pending clears.
  - If shadow header_en=0, hdr_pending is simply cleared.
- Hold register (one entry):
  - A candidate that loses the slot goes into hold.
  - If hold is already full, the new candidate is dropped and drop_ctr increments, saturating.
  - A held word is emitted in the next free slot.
- Latency: a candidate with no contention appears on out/out_valid in the cycle after its final in_valid.
- Framing:
  - The frame counter counts emitted data words only; headers are not counted.
  - When an emitted data word is number L of the frame (L = max(shadow frame_len, 1)), frame_end=1 in the same cycle as that out_valid.
  - In that cycle the frame counter clears and hdr_pending sets, so the header occupies the following cycle.
- Boundary cases:
  - A candidate that completes in the header cycle goes to hold.
  - With continuous in_valid at A=0 and headers enabled, exactly one word is dropped per frame once the hold register is already occupied.
- Reset mid-operation discards hold, accumulators, pending header and partial frame. The first word after reset is a header (seq=0) if header_en is high at release.

Test Plan:
- header_en=0, A=0, frame_len=4, in_valid every 10 cycles with in=ramp 1,2,3… → out equals in one cycle later; frame_end on the 4th, 8th, … word; drop_ctr=0.
- A=2, NUM_CHANNELS=8, channel 0 inputs 10,11,12,14, other channels 0xFFFF → one out word: ch0=11, others=0xFFFF, valid one cycle after the 4th input.
- header_en=1, frame_len=2, sparse input → stream is header(seq=0), d, d(frame_end), header(seq=1), …; magic=0xA5A5; the A field matches.
- header_en=1, A=0, frame_len=3, in_valid every cycle for 20 cycles → no word duplicated; each drop_ctr increment matches a missing input; header drop field equals drop_ctr at emission.
- Change frame_len 4→2 mid-frame → current frame still ends after 4 words; the next frame ends after 2; frame_len=0 gives frame_end on every word.
- Assert rst for 1 cycle mid-group and mid-frame → outputs 0 next cycle; first word after release is a header with seq=0; partial accumulator contents never appear on out.
